dm_cache_fsm: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller. It sits between the CPU request port and main memory. It acts as the initiator that drives the cache data array and tag array over the `cache_req_type` index/write-enable interface, and it also drives a 128-bit line-based memory interface. The cache has 1024 lines of 16 bytes (16 KiB). Reads of both arrays are combinational, and writes take effect on the clock edge.

---
 rtl/cache_def.sv | 45 ++++
 rtl/dm_cache_tag.sv | 23 ++
 rtl/dm_cache_fsm.sv | 114 +++++++++++
 tb/tb_dm_cache_fsm.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_def.sv
// cache_def: shared types, state encoding and address-split constants for the
// direct-mapped write-back cache controller.
package cache_def;
  localparam int TAGMSB = 31;
  localparam int TAGLSB = 14;

  typedef enum logic [1:0] {IDLE, COMPARE_TAG, ALLOCATE, WRITE_BACK} cache_state_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef struct packed {
    logic                     valid;
    logic                     dirty;
    logic [TAGMSB-TAGLSB:0]   tag;
  } cache_tag_type;

  typedef struct packed {
    logic [9:0] index;
    logic       we;
  } cache_req_type;

  typedef logic [127:0] cache_data_type;
endpackage

// File: rtl/dm_cache_tag.sv
// dm_cache_tag: 1024-entry tag array, combinational read, clocked write,
// cleared to zero by its own reset.
module dm_cache_tag
  import cache_def::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  cache_req_type tag_req,
  input  cache_tag_type tag_write,
  output cache_tag_type tag_read
);
  cache_tag_type r_tags [1024];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) r_tags[i] <= '0;
    end else if (tag_req.we) begin
      r_tags[tag_req.index] <= tag_write;
    end
  end

  assign tag_read = r_tags[tag_req.index];
endmodule

// File: rtl/dm_cache_fsm.sv
// dm_cache_fsm: direct-mapped write-back/write-allocate cache controller.
// Define DM_CACHE_STATS_EN to add hit_cnt/miss_cnt counter outputs.
module dm_cache_fsm
  import cache_def::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  cpu_req_type    cpu_req,
  output cpu_result_type cpu_res,
  output mem_req_type    mem_req,
  input  mem_data_type   mem_data,
  output cache_req_type  tag_req,
  output cache_tag_type  tag_write,
  input  cache_tag_type  tag_read,
  output cache_req_type  data_req,
  output cache_data_type data_write,
  input  cache_data_type data_read
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt
`endif
);
  cache_state_type          r_state, w_state_nx;
  cpu_req_type              r_req;
  mem_req_type              r_mem_req, w_mem_nx, w_rd_req;
  cache_data_type           w_merged;
  logic [TAGMSB-TAGLSB:0]   w_tag;
  logic [9:0]               w_index;
  logic [1:0]               w_word;
  logic                     w_hit;

  assign w_tag    = r_req.addr[TAGMSB:TAGLSB];
  assign w_index  = r_req.addr[13:4];
  assign w_word   = r_req.addr[3:2];
  assign w_hit    = tag_read.valid && (tag_read.tag == w_tag);
  assign w_rd_req = '{addr: {w_tag, w_index, 4'b0}, data: '0, rw: 1'b0, valid: 1'b1};
  assign mem_req  = r_mem_req;

  always_comb begin
    w_state_nx = r_state;
    w_mem_nx   = r_mem_req;
    w_merged   = data_read;
    w_merged[32*w_word +: 32] = r_req.data;
    cpu_res    = '0;
    tag_req    = '{index: w_index, we: 1'b0};
    data_req   = '{index: w_index, we: 1'b0};
    tag_write  = '{valid: 1'b1, dirty: 1'b0, tag: w_tag};
    data_write = mem_data.data;
    case (r_state)
      IDLE: w_state_nx = cpu_req.valid ? COMPARE_TAG : IDLE;
      COMPARE_TAG: begin
        if (w_hit) begin
          w_state_nx      = IDLE;
          cpu_res.ready   = 1'b1;
          cpu_res.data    = r_req.rw ? 32'h0 : data_read[32*w_word +: 32];
          tag_req.we      = r_req.rw;
          data_req.we     = r_req.rw;
          tag_write.dirty = 1'b1;
          data_write      = w_merged;
        end else if (tag_read.valid && tag_read.dirty) begin
          w_mem_nx   = '{addr: {tag_read.tag, w_index, 4'b0}, data: data_read, rw: 1'b1, valid: 1'b1};
          w_state_nx = WRITE_BACK;
        end else begin
          w_mem_nx   = w_rd_req;
          w_state_nx = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        w_mem_nx   = mem_data.ready ? w_rd_req : r_mem_req;
        w_state_nx = mem_data.ready ? ALLOCATE : WRITE_BACK;
      end
      ALLOCATE: begin
        // Refill lands clean; the re-compare merges any pending write.
        w_mem_nx.valid = r_mem_req.valid && !mem_data.ready;
        tag_req.we     = mem_data.ready;
        data_req.we    = mem_data.ready;
        w_state_nx     = mem_data.ready ? COMPARE_TAG : ALLOCATE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_mem_req <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_mem_req <= w_mem_nx;
      if (r_state == IDLE && cpu_req.valid) r_req <= cpu_req;
    end
  end

`ifdef DM_CACHE_STATS_EN
  logic r_refill;

  // r_refill marks the re-compare after a line fill so it is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refill <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      r_refill <= (r_state != IDLE) && (r_refill || (r_state == ALLOCATE && mem_data.ready));
      if (r_state == COMPARE_TAG && !r_refill) begin
        hit_cnt  <= hit_cnt + {31'd0, w_hit};
        miss_cnt <= miss_cnt + {31'd0, !w_hit};
      end
    end
  end
`endif
endmodule

// File: tb/tb_dm_cache_fsm.sv
// tb_dm_cache_fsm: randomized bench with a line-level cache/memory model,
// external tag/data arrays and a responding main memory.
module tb_dm_cache_fsm;
  import cache_def::*;

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
    int           lat;
  } mtx_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           por_n = 1'b0;
  cpu_req_type    cpu_req;
  cpu_result_type cpu_res;
  mem_req_type    mem_req;
  mem_data_type   mem_data;
  cache_req_type  tag_req, data_req;
  cache_tag_type  tag_write, tag_read;
  cache_data_type data_write, data_read;
`ifdef DM_CACHE_STATS_EN
  logic [31:0]    hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dm_cache_fsm dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_res(cpu_res),
    .mem_req(mem_req), .mem_data(mem_data),
    .tag_req(tag_req), .tag_write(tag_write), .tag_read(tag_read),
    .data_req(data_req), .data_write(data_write), .data_read(data_read)
`ifdef DM_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  dm_cache_tag u_tag (
    .clk(clk), .rst_n(por_n), .tag_req(tag_req), .tag_write(tag_write), .tag_read(tag_read)
  );

  logic [127:0] darr [1024];
  initial for (int i = 0; i < 1024; i++) darr[i] = '0;
  always @(posedge clk) if (data_req.we) darr[data_req.index] <= data_write;
  assign data_read = darr[data_req.index];

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         m_valid [1024];
  logic         m_dirty [1024];
  logic [17:0]  m_tag   [1024];
  logic [127:0] m_line  [1024];
  logic [127:0] mem_model [logic [31:0]];
  mtx_t         mq [$];
  int           hits = 0, misses = 0;

  logic         exp_on = 1'b0, exp_rw = 1'b0;
  int           exp_cyc = 0;
  logic [31:0]  exp_data = '0;
  int           last_ready = -10, last_lat = 0;
  logic [31:0]  last_data;
  logic [31:0]  last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a + 32'h3000_0003, a + 32'h2000_0002, a + 32'h1000_0001, a ^ 32'hF000_0000};
  endfunction

  // Whole-access model: decides hit/miss, queues the memory traffic it implies
  // and returns the total CPU latency from the accept cycle.
  task automatic model_access(input logic [31:0] a, input logic [31:0] d, input logic rw,
                              input int lrd, input int lwb, output int lat);
    logic [9:0] idx;
    logic [17:0] tg;
    int w;
    mtx_t e;
    idx = a[13:4];
    tg  = a[31:14];
    w   = int'(a[3:2]);
    lat = 1;
    if (m_valid[idx] && m_tag[idx] == tg) hits++;
    else begin
      misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        e = '{rw: 1'b1, addr: {m_tag[idx], idx, 4'b0}, data: m_line[idx], lat: lwb};
        mq.push_back(e);
        mem_model[e.addr] = m_line[idx];
        lat += 1 + lwb;
      end
      e = '{rw: 1'b0, addr: {tg, idx, 4'b0}, data: '0, lat: lrd};
      e.data = line_of(e.addr);
      mq.push_back(e);
      m_line[idx] = e.data;
      m_valid[idx] = 1'b1;
      m_tag[idx] = tg;
      m_dirty[idx] = 1'b0;
      lat += 2 + lrd;
    end
    if (rw) begin
      m_line[idx][32*w +: 32] = d;
      m_dirty[idx] = 1'b1;
    end
    exp_data = m_line[idx][32*w +: 32];
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic rw,
                        input int lrd, input int lwb);
    int lat, acc;
    bit got;
    model_access(a, d, rw, lrd, lwb, lat);
    acc = (cyc == last_ready) ? cyc + 2 : cyc + 1;
    cpu_req = '{addr: a, data: d, rw: rw, valid: 1'b1};
    exp_rw = rw;
    exp_cyc = acc + lat - 1;
    exp_on = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk); #1;
      if (cpu_res.ready) begin
        got = 1'b1;
        last_ready = cyc;
        last_data = cpu_res.data;
        last_lat = cyc - acc + 1;
      end else if (cyc >= acc) begin
        cpu_req = '{addr: $urandom, data: $urandom, rw: 1'($urandom), valid: 1'($urandom)};
      end
    end
    if (!got) begin
      checks++;
      errors++;
      exp_on = 1'b0;
      $display("FAIL access_timeout: addr %h got no ready want ready by cycle %0d", a, exp_cyc);
    end
  endtask

  task automatic idle(input int n);
    cpu_req = '0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Compare process; also plays main memory so its latency matches the model.
  bit           txn_open = 1'b0;
  int           left = 0;
  mtx_t         cur;
  mem_req_type  hold;
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      txn_open = 1'b0;
      mem_data = '0;
    end else begin
      chk("cpu_ready", 128'(cpu_res.ready), 128'(exp_on && cyc == exp_cyc));
      if (cpu_res.ready && exp_on && !exp_rw) chk("cpu_rdata", 128'(cpu_res.data), 128'(exp_data));
      if (!cpu_res.ready) chk("cpu_data_idle", 128'(cpu_res.data), 128'(0));
      if (cpu_res.ready) exp_on = 1'b0;
      if (mem_data.ready) begin
        mem_data.ready = 1'b0;
        txn_open = 1'b0;
      end
      if (mem_req.valid) begin
        if (!txn_open) begin
          if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: got request %h rw %0d want none", mem_req.addr, mem_req.rw);
          end else begin
            cur = mq.pop_front();
            chk("mem_rw", 128'(mem_req.rw), 128'(cur.rw));
            chk("mem_addr", 128'(mem_req.addr), 128'(cur.addr));
            if (cur.rw) begin
              chk("mem_wdata", mem_req.data, cur.data);
              last_wb_addr = mem_req.addr;
              last_wb_data = mem_req.data;
            end
            hold = mem_req;
            txn_open = 1'b1;
            left = cur.lat;
          end
        end else chk("mem_hold", 128'(mem_req.addr ^ 32'(mem_req.rw)) ^ mem_req.data,
                     128'(hold.addr ^ 32'(hold.rw)) ^ hold.data);
        if (txn_open) begin
          if (left == 0) begin
            mem_data.ready = 1'b1;
            mem_data.data = cur.rw ? {$urandom, $urandom, $urandom, $urandom} : cur.data;
          end else left--;
        end
      end else begin
        if (txn_open) begin
          checks++;
          errors++;
          txn_open = 1'b0;
          $display("FAIL mem_valid_drop: got valid 0 want 1 (pending %h)", cur.addr);
        end
        // Stray ready pulses with no request outstanding must be ignored.
        if ($urandom_range(0, 7) == 0) begin
          mem_data.ready = 1'b1;
          mem_data.data = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int lat, r1;
    logic         sv_valid, sv_dirty;
    logic [17:0]  sv_tag;
    logic [127:0] sv_line;
    logic [31:0]  a;
    for (int i = 0; i < 1024; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_line[i] = '0;
    end
    cpu_req = '0;
    mem_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cpu_res", 128'(cpu_res), 128'(0));
    chk("rst_mem_req", 128'(mem_req.addr) ^ mem_req.data ^ 128'({mem_req.rw, mem_req.valid}), 128'(0));
    chk("rst_we", 128'({tag_req.we, data_req.we}), 128'(0));
    chk("rst_index", 128'(tag_req.index), 128'(0));
    por_n = 1'b1;
    rst_n = 1'b1;
    @(negedge clk); #1;

    mem_model[32'h1230] = {32'hC3C3_0003, 32'hC2C2_0002, 32'hDEAD_BEEF, 32'hC0C0_0000};
    access(32'h0000_1234, 32'h0, 1'b0, 2, 0);
    chk("cold_data", 128'(last_data), 128'(32'hDEAD_BEEF));
    chk("cold_lat", 128'(last_lat), 128'(5));
    chk("cold_tag", 128'(tag_read), 128'({1'b1, 1'b0, 18'd0}));
    idle(2);
    access(32'h0000_1238, 32'h1111_2222, 1'b1, 0, 0);
    chk("whit_lat", 128'(last_lat), 128'(1));
    idle(1);
    access(32'h0000_1238, 32'h0, 1'b0, 0, 0);
    chk("rhit_data", 128'(last_data), 128'(32'h1111_2222));
    idle(1);
    access(32'h0000_5230, 32'h0, 1'b0, 1, 1);
    chk("evict_lat", 128'(last_lat), 128'(6));
    chk("evict_addr", 128'(last_wb_addr), 128'(32'h0000_1230));
    chk("evict_lane2", 128'(last_wb_data[95:64]), 128'(32'h1111_2222));
`ifdef DM_CACHE_STATS_EN
    chk("stats_hits_lit", 128'(hit_cnt), 128'(2));
    chk("stats_miss_lit", 128'(miss_cnt), 128'(2));
`endif
    idle(1);
    access(32'h0000_5234, 32'h0, 1'b0, 0, 0);
    r1 = last_ready;
    access(32'h0000_5238, 32'h0, 1'b0, 0, 0);
    chk("b2b_gap", 128'(last_ready - r1), 128'(2));
    chk("b2b_lat", 128'(last_lat), 128'(1));

    idle(1);
    sv_valid = m_valid[10'h123]; sv_dirty = m_dirty[10'h123];
    sv_tag = m_tag[10'h123]; sv_line = m_line[10'h123];
    model_access(32'h0000_9230, 32'h0, 1'b0, 30, 0, lat);
    cpu_req = '{addr: 32'h0000_9230, data: 32'h0, rw: 1'b0, valid: 1'b1};
    for (int i = 0; i < 10 && !mem_req.valid; i++) begin @(negedge clk); #1; end
    cpu_req = '0;
    @(negedge clk); #1;
    chk("alloc_pending", 128'(mem_req.valid), 128'(1));
    #1 rst_n = 1'b0;
    exp_on = 1'b0;
    #1;
    chk("arst_mem_valid", 128'(mem_req.valid), 128'(0));
    chk("arst_we", 128'({tag_req.we, data_req.we}), 128'(0));
    chk("arst_ready", 128'(cpu_res.ready), 128'(0));
    m_valid[10'h123] = sv_valid; m_dirty[10'h123] = sv_dirty;
    m_tag[10'h123] = sv_tag; m_line[10'h123] = sv_line;
    hits = 0;
    misses = 0;
    last_ready = -10;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    access(32'h0000_5230, 32'h0, 1'b0, 0, 0);
    chk("post_rst_lat", 128'(last_lat), 128'(1));

    for (int n = 0; n < 250; n++) begin
      a = (32'($urandom_range(0, 3)) << 14) | (32'(10'h120 + 10'($urandom_range(0, 5))) << 4)
          | 32'($urandom_range(0, 15));
      access(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("mq_drained", 128'(mq.size()), 128'(0));
`ifdef DM_CACHE_STATS_EN
    chk("stats_hits", 128'(hit_cnt), 128'(hits));
    chk("stats_miss", 128'(miss_cnt), 128'(misses));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
